mc_control_unit: RTL and testbench

- Multicycle control FSM for the 16-bit CPU.
- Sequences the PC register (pc_write/pc_src), instruction register, memory port, register file and ALU muxes, one instruction at a time.
- Drives the memory request/ready handshake and keeps the halt flag and the retired-instruction count.

---
 rtl/mc_ctrl_pkg.sv | 87 ++++++++
 rtl/mc_inst_decode.sv | 59 +++++
 rtl/mc_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared ISA encodings, FSM state type and datapath mux encodings for the
// multicycle control unit of the 16-bit CPU.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BNE   = 4'd0,
    OP_BEQ   = 4'd1,
    OP_BGZ   = 4'd2,
    OP_BLZ   = 4'd3,
    OP_ADI   = 4'd4,
    OP_ORI   = 4'd5,
    OP_LHI   = 4'd6,
    OP_LWD   = 4'd7,
    OP_SWD   = 4'd8,
    OP_JMP   = 4'd9,
    OP_JAL   = 4'd10,
    OP_RTYPE = 4'd15
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'd0,
    FN_SUB = 6'd1,
    FN_AND = 6'd2,
    FN_ORR = 6'd3,
    FN_NOT = 6'd4,
    FN_TCP = 6'd5,
    FN_SHL = 6'd6,
    FN_SHR = 6'd7,
    FN_JPR = 6'd25,
    FN_JRL = 6'd26,
    FN_WWD = 6'd28,
    FN_HLT = 6'd29
  } func_e;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    PC_SRC_NEXT   = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_RS     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    REG_DST_RT = 2'd0,
    REG_DST_RD = 2'd1,
    REG_DST_R2 = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    ALU_B_RT   = 2'd0,
    ALU_B_SIMM = 2'd1,
    ALU_B_ZIMM = 2'd2,
    ALU_B_HIMM = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_CTRL_ADD  = 2'd0,
    ALU_CTRL_FUNC = 2'd1,
    ALU_CTRL_OP   = 2'd2,
    ALU_CTRL_CMP  = 2'd3
  } alu_ctrl_e;

  // Control bundle driven by the FSM each cycle; zero means "no action".
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_sel;
    logic       output_port_en;
  } ctl_t;

endpackage

// File: rtl/mc_inst_decode.sv
// Combinational classification of the current instruction (opcode/func)
// into the instruction classes the control FSM sequences on.
module mc_inst_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func_code,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_jr,
  output logic       is_link,
  output logic       is_load,
  output logic       is_store,
  output logic       is_rtype_alu,
  output logic       is_wwd,
  output logic       is_hlt,
  output logic       is_nop
);

  always_comb begin
    is_branch    = 1'b0;
    is_jump      = 1'b0;
    is_jr        = 1'b0;
    is_link      = 1'b0;
    is_load      = 1'b0;
    is_store     = 1'b0;
    is_rtype_alu = 1'b0;
    is_wwd       = 1'b0;
    is_hlt       = 1'b0;
    is_nop       = 1'b0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: is_branch = 1'b1;
      OP_ADI, OP_ORI, OP_LHI:         ;
      OP_LWD:                         is_load   = 1'b1;
      OP_SWD:                         is_store  = 1'b1;
      OP_JMP:                         is_jump   = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        is_link = 1'b1;
      end
      OP_RTYPE: begin
        case (func_code)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: is_rtype_alu = 1'b1;
          FN_JPR:                         is_jr        = 1'b1;
          FN_JRL: begin
            is_jr   = 1'b1;
            is_link = 1'b1;
          end
          FN_WWD:                         is_wwd       = 1'b1;
          FN_HLT:                         is_hlt       = 1'b1;
          default:                        is_nop       = 1'b1;
        endcase
      end
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives the memory handshake, and tracks halt and retired-instruction count.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INST_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func_code,
  input  logic                  bcond,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  ir_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  i_or_d,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic                  mem_to_reg,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_ctrl_sel,
  output logic                  output_port_en,
  output logic                  is_halted,
  output logic [NUM_INST_W-1:0] num_inst
);

  state_e                state_q, state_d;
  logic                  is_halted_q, is_halted_d;
  logic [NUM_INST_W-1:0] num_inst_q, num_inst_d;
  ctl_t                  ctl;
  logic                  halt_entry;

  logic is_branch, is_jump, is_jr, is_link, is_load, is_store;
  logic is_rtype_alu, is_wwd, is_hlt, is_nop;

  mc_inst_decode u_decode (
    .opcode       (opcode),
    .func_code    (func_code),
    .is_branch    (is_branch),
    .is_jump      (is_jump),
    .is_jr        (is_jr),
    .is_link      (is_link),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_rtype_alu (is_rtype_alu),
    .is_wwd       (is_wwd),
    .is_hlt       (is_hlt),
    .is_nop       (is_nop)
  );

  always_comb begin
    state_d    = state_q;
    ctl        = '0;
    halt_entry = 1'b0;
    case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          state_d      = S_ID;
        end
      end
      S_ID: begin
        state_d = S_IF;
        if (is_jump) begin
          ctl.pc_write  = 1'b1;
          ctl.pc_src    = PC_SRC_JUMP;
          ctl.reg_write = is_link;
          ctl.reg_dst   = is_link ? REG_DST_R2 : REG_DST_RT;
        end else if (is_jr) begin
          ctl.pc_write  = 1'b1;
          ctl.pc_src    = PC_SRC_RS;
          ctl.reg_write = is_link;
          ctl.reg_dst   = is_link ? REG_DST_R2 : REG_DST_RT;
        end else if (is_wwd) begin
          ctl.output_port_en = 1'b1;
          ctl.pc_write       = 1'b1;
          ctl.pc_src         = PC_SRC_NEXT;
        end else if (is_hlt) begin
          halt_entry = 1'b1;
          state_d    = S_HALT;
        end else if (is_nop) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_SRC_NEXT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_branch) begin
          ctl.alu_ctrl_sel = ALU_CTRL_CMP;
          ctl.pc_write     = 1'b1;
          ctl.pc_src       = bcond ? PC_SRC_BRANCH : PC_SRC_NEXT;
          state_d          = S_IF;
        end else if (is_load || is_store) begin
          ctl.alu_src_b    = ALU_B_SIMM;
          ctl.alu_ctrl_sel = ALU_CTRL_ADD;
          state_d          = S_MEM;
        end else if (is_rtype_alu) begin
          ctl.alu_src_b    = ALU_B_RT;
          ctl.alu_ctrl_sel = ALU_CTRL_FUNC;
          state_d          = S_WB;
        end else begin
          ctl.alu_ctrl_sel = ALU_CTRL_OP;
          state_d          = S_WB;
          case (opcode)
            OP_ADI:  ctl.alu_src_b = ALU_B_SIMM;
            OP_ORI:  ctl.alu_src_b = ALU_B_ZIMM;
            OP_LHI:  ctl.alu_src_b = ALU_B_HIMM;
            // Only reachable if IR changed under the FSM: retire as a NOP.
            default: begin
              ctl.alu_ctrl_sel = ALU_CTRL_ADD;
              ctl.pc_write     = 1'b1;
              state_d          = S_IF;
            end
          endcase
        end
      end
      S_MEM: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_read  = is_load;
        ctl.mem_write = is_store;
        if (mem_ready) begin
          if (is_store) begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = PC_SRC_NEXT;
            state_d      = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = is_rtype_alu ? REG_DST_RD : REG_DST_RT;
        ctl.mem_to_reg = is_load;
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_SRC_NEXT;
        state_d        = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Outputs are combinational so reset withdraws a pending request at once.
    if (!reset_n) begin
      ctl        = '0;
      halt_entry = 1'b0;
      state_d    = S_IF;
    end

    is_halted_d = is_halted_q | halt_entry;
    num_inst_d  = num_inst_q + NUM_INST_W'(ctl.pc_write | halt_entry);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IF;
      is_halted_q <= 1'b0;
      num_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      is_halted_q <= is_halted_d;
      num_inst_q  <= num_inst_d;
    end
  end

  assign pc_write       = ctl.pc_write;
  assign pc_src         = ctl.pc_src;
  assign ir_write       = ctl.ir_write;
  assign mem_read       = ctl.mem_read;
  assign mem_write      = ctl.mem_write;
  assign i_or_d         = ctl.i_or_d;
  assign reg_write      = ctl.reg_write;
  assign reg_dst        = ctl.reg_dst;
  assign mem_to_reg     = ctl.mem_to_reg;
  assign alu_src_b      = ctl.alu_src_b;
  assign alu_ctrl_sel   = ctl.alu_ctrl_sel;
  assign output_port_en = ctl.output_port_en;
  assign is_halted      = is_halted_q;
  assign num_inst       = num_inst_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed latency table, randomized
// instruction stream against an instruction-level reference model, and
// hand-written halt and mid-memory reset sequences.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        bcond;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic        mem_to_reg, output_port_en, is_halted;
  logic [1:0]  pc_src, reg_dst, alu_src_b, alu_ctrl_sel;
  logic [15:0] num_inst;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned model_cnt   = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.NUM_INST_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .opcode         (opcode),
    .func_code      (func_code),
    .bcond          (bcond),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .ir_write       (ir_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .i_or_d         (i_or_d),
    .reg_write      (reg_write),
    .reg_dst        (reg_dst),
    .mem_to_reg     (mem_to_reg),
    .alu_src_b      (alu_src_b),
    .alu_ctrl_sel   (alu_ctrl_sel),
    .output_port_en (output_port_en),
    .is_halted      (is_halted),
    .num_inst       (num_inst)
  );

  // Bit order: pw, pc_src[2], irw, mr, mw, iod, rw, reg_dst[2], m2r, alu_b[2], alu_ctrl[2], ope
  function automatic logic [15:0] mk(input logic pw, input logic [1:0] ps, input logic irw,
                                     input logic mr, input logic mw, input logic iod,
                                     input logic rw, input logic [1:0] rd, input logic m2r,
                                     input logic [1:0] asb, input logic [1:0] acs,
                                     input logic ope);
    return {pw, ps, irw, mr, mw, iod, rw, rd, m2r, asb, acs, ope};
  endfunction

  function automatic logic [15:0] dut_ctl();
    return {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
            mem_to_reg, alu_src_b, alu_ctrl_sel, output_port_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef enum {K_BR, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_JMP, K_JAL,
                K_R, K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_e;

  typedef struct {
    logic [15:0] ctl;
    logic        rdy;
    logic        in_if;
    logic        use_bc;
    logic        halt;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic kind_e classify(input int op, input int fn);
    if (op <= 3) return K_BR;
    case (op)
      4: return K_ADI;
      5: return K_ORI;
      6: return K_LHI;
      7: return K_LWD;
      8: return K_SWD;
      9: return K_JMP;
      10: return K_JAL;
      15: begin
        if (fn <= 7) return K_R;
        if (fn == 25) return K_JPR;
        if (fn == 26) return K_JRL;
        if (fn == 28) return K_WWD;
        if (fn == 29) return K_HLT;
        return K_NOP;
      end
      default: return K_NOP;
    endcase
  endfunction

  task automatic push(input logic [15:0] c, input logic rdy, input logic in_if,
                      input logic use_bc, input logic halt);
    exp_q.push_back('{ctl: c, rdy: rdy, in_if: in_if, use_bc: use_bc, halt: halt});
  endtask

  task automatic build(input int op, input int fn, input logic bc,
                       input int unsigned wif, input int unsigned wmem);
    kind_e k = classify(op, fn);
    logic [15:0] z = '0;
    for (int unsigned w = 0; w < wif; w++) push(mk(0,0,0,1,0,0,0,0,0,0,0,0), 0, 1, 0, 0);
    push(mk(0,0,1,1,0,0,0,0,0,0,0,0), 1, 1, 0, 0);
    case (k)
      K_JMP: push(mk(1,2,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0);
      K_JAL: push(mk(1,2,0,0,0,0,1,2,0,0,0,0), 0, 0, 0, 0);
      K_JPR: push(mk(1,3,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0);
      K_JRL: push(mk(1,3,0,0,0,0,1,2,0,0,0,0), 0, 0, 0, 0);
      K_WWD: push(mk(1,0,0,0,0,0,0,0,0,0,0,1), 0, 0, 0, 0);
      K_NOP: push(mk(1,0,0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0);
      K_HLT: push(z, 0, 0, 0, 1);
      default: begin
        push(z, 0, 0, 0, 0);
        case (k)
          K_BR:  push(mk(1,{1'b0,bc},0,0,0,0,0,0,0,0,3,0), 0, 0, 1, 0);
          K_R:   push(mk(0,0,0,0,0,0,0,0,0,0,1,0), 0, 0, 0, 0);
          K_ADI: push(mk(0,0,0,0,0,0,0,0,0,1,2,0), 0, 0, 0, 0);
          K_ORI: push(mk(0,0,0,0,0,0,0,0,0,2,2,0), 0, 0, 0, 0);
          K_LHI: push(mk(0,0,0,0,0,0,0,0,0,3,2,0), 0, 0, 0, 0);
          default: begin
            logic ld = (k == K_LWD);
            push(mk(0,0,0,0,0,0,0,0,0,1,0,0), 0, 0, 0, 0);
            for (int unsigned w = 0; w < wmem; w++)
              push(mk(0,0,0,ld,!ld,1,0,0,0,0,0,0), 0, 0, 0, 0);
            push(mk(!ld,0,0,ld,!ld,1,0,0,0,0,0,0), 1, 0, 0, 0);
          end
        endcase
        if (k != K_BR && k != K_SWD)
          push(mk(1,0,0,0,0,0,1,{1'b0,(k == K_R)},(k == K_LWD),0,0,0), 0, 0, 0, 0);
      end
    endcase
  endtask

  task automatic run_model(input int op, input int fn, input logic bc,
                           input int unsigned wif, input int unsigned wmem);
    cyc_t c;
    logic req;
    build(op, fn, bc, wif, wmem);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      req = c.ctl[11] | c.ctl[10];
      @(negedge clk);
      opcode    = c.in_if ? 4'($urandom) : 4'(op);
      func_code = c.in_if ? 6'($urandom) : 6'(fn);
      bcond     = c.use_bc ? bc : 1'($urandom);
      mem_ready = req ? c.rdy : 1'($urandom);
      #1;
      chk($sformatf("model_ctl op%0d fn%0d", op, fn), 32'(dut_ctl()), 32'(c.ctl));
      chk("model_num_inst", 32'(num_inst), 32'(16'(model_cnt)));
      if (c.ctl[15] || c.halt) model_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 4'($urandom);
    func_code = 6'($urandom);
    #1;
    chk("reset_ctl_zero", 32'(dut_ctl()), 32'h0);
    @(negedge clk);
    #1;
    chk("reset_num_inst", 32'(num_inst), 32'h0);
    chk("reset_is_halted", 32'(is_halted), 32'h0);
    model_cnt = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- directed latency table ----------------
  typedef struct {
    int          op;
    int          fn;
    logic        bc;
    int unsigned wif;
    int unsigned wmem;
    int unsigned exp_cyc;
    logic [15:0] exp_ctl;
  } tvec_t;

  tvec_t tbl[13];

  task automatic run_table();
    for (int i = 0; i < 13; i++) begin
      int unsigned cyc = 0;
      int unsigned wc  = 0;
      logic        done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
        @(negedge clk);
        opcode    = 4'(tbl[i].op);
        func_code = 6'(tbl[i].fn);
        bcond     = tbl[i].bc;
        mem_ready = 1'b0;
        #1;
        if (mem_read || mem_write) begin
          mem_ready = (wc >= (i_or_d ? tbl[i].wmem : tbl[i].wif));
          wc = mem_ready ? 0 : wc + 1;
        end else begin
          mem_ready = 1'($urandom);
        end
        #1;
        cyc++;
        if (pc_write) begin
          done = 1'b1;
          chk($sformatf("tbl%0d_retire_ctl", i), 32'(dut_ctl()), 32'(tbl[i].exp_ctl));
          chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].exp_cyc);
        end
      end
      if (!done) chk($sformatf("tbl%0d_retire_timeout", i), 32'h0, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_num_inst", i), 32'(num_inst), 32'(i + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                op  fn  bc wif wmem cyc  retire-cycle control vector
    tbl[0]  = '{4,  0,  0, 0, 0, 4,  mk(1,0,0,0,0,0,1,0,0,0,0,0)};   // ADI
    tbl[1]  = '{7,  0,  0, 3, 2, 10, mk(1,0,0,0,0,0,1,0,1,0,0,0)};   // LWD w/ waits
    tbl[2]  = '{1,  0,  1, 0, 0, 3,  mk(1,1,0,0,0,0,0,0,0,0,3,0)};   // BEQ taken
    tbl[3]  = '{1,  0,  0, 0, 0, 3,  mk(1,0,0,0,0,0,0,0,0,0,3,0)};   // BEQ not taken
    tbl[4]  = '{10, 0,  0, 0, 0, 2,  mk(1,2,0,0,0,0,1,2,0,0,0,0)};   // JAL
    tbl[5]  = '{15, 25, 0, 0, 0, 2,  mk(1,3,0,0,0,0,0,0,0,0,0,0)};   // JPR
    tbl[6]  = '{15, 26, 0, 1, 0, 3,  mk(1,3,0,0,0,0,1,2,0,0,0,0)};   // JRL
    tbl[7]  = '{15, 28, 0, 0, 0, 2,  mk(1,0,0,0,0,0,0,0,0,0,0,1)};   // WWD
    tbl[8]  = '{8,  0,  0, 0, 1, 5,  mk(1,0,0,0,1,1,0,0,0,0,0,0)};   // SWD
    tbl[9]  = '{15, 0,  0, 0, 0, 4,  mk(1,0,0,0,0,0,1,1,0,0,0,0)};   // ADD
    tbl[10] = '{12, 0,  0, 0, 0, 2,  mk(1,0,0,0,0,0,0,0,0,0,0,0)};   // unknown opcode
    tbl[11] = '{5,  0,  0, 2, 0, 6,  mk(1,0,0,0,0,0,1,0,0,0,0,0)};   // ORI w/ waits
    tbl[12] = '{15, 40, 0, 0, 0, 2,  mk(1,0,0,0,0,0,0,0,0,0,0,0)};   // unknown func

    reset_n   = 1'b0;
    opcode    = '0;
    func_code = '0;
    bcond     = 1'b0;
    mem_ready = 1'b0;

    do_reset();
    run_table();

    // Randomized stream against the reference model (HLT excluded).
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int op = int'($urandom_range(0, 15));
      int fn = int'($urandom_range(0, 63));
      if (op == 15) begin
        case ($urandom_range(0, 3))
          0: fn = int'($urandom_range(0, 7));
          1: fn = (n % 3 == 0) ? 25 : ((n % 3 == 1) ? 26 : 28);
          2: fn = int'($urandom_range(8, 24));
          default: ;
        endcase
        if (fn == 29) fn = 0;
      end
      run_model(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Halt after three instructions, then stay quiet.
    do_reset();
    run_model(4, 0, 0, 0, 0);
    run_model(9, 0, 0, 1, 0);
    run_model(1, 0, 1, 0, 0);
    run_model(15, 29, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode    = 4'($urandom);
      #1;
      chk("halt_quiet_ctl", 32'(dut_ctl()), 32'h0);
      chk("halt_is_halted", 32'(is_halted), 32'h1);
      chk("halt_num_inst", 32'(num_inst), 32'h4);
    end

    // Reset asserted while SWD waits in MEM.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      opcode    = 4'd8;
      func_code = '0;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("swd_mem_write", 32'({mem_write, i_or_d}), 32'h3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("swd_reset_ctl", 32'(dut_ctl()), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_fetch", 32'({mem_read, i_or_d, mem_write}), 32'h4);
    chk("post_reset_num_inst", 32'(num_inst), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
